// File: rtl/hs32_aict_pkg.sv
// Shared constants and FSM encodings for the hs32_aict interrupt controller.
package hs32_aict_pkg;
  localparam int MAX_NI = 24;

  localparam logic [4:0] IDX_PENDING = 5'd24;
  localparam logic [4:0] IDX_CTRL    = 5'd25;

  typedef enum logic {BUS_IDLE = 1'b0, BUS_ACK = 1'b1} bus_state_t;
  typedef enum logic {INT_IDLE = 1'b0, INT_REQ = 1'b1} int_state_t;
endpackage

// File: rtl/hs32_aict_prio.sv
// Combinational lowest-index-first priority picker.
module hs32_aict_prio import hs32_aict_pkg::*; #(
  parameter int NI = MAX_NI
) (
  input  logic [NI-1:0] req,
  output logic          vld,
  output logic [4:0]    idx
);
  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = NI - 1; i >= 0; i--)
      if (req[i]) idx = 5'(i);
  end
endmodule

// File: rtl/hs32_aict.sv
// Vectored interrupt controller with a bus-mapped handler table.
// Define HS32_AICT_EDGE_EN for rising-edge irq detection; default is level.
module hs32_aict import hs32_aict_pkg::*; #(
  parameter int NI = MAX_NI
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stb,
  output logic          ack,
  input  logic [31:0]   addr,
  input  logic [31:0]   dtw,
  input  logic          rw,
  output logic [31:0]   dtr,
  input  logic [NI-1:0] irq,
  output logic          int_req,
  output logic [31:0]   int_vec,
  output logic [4:0]    int_line,
  input  logic          int_ack
);
  bus_state_t bus_st, bus_nxt;
  int_state_t int_st, int_nxt;

  logic [NI-1:0][31:0] tbl;
  logic [NI-1:0] pending, pend_nxt, en, evt, bus_clr, ack_clr, elig;
  logic          gen, bus_go, wr, take, load, pr_vld;
  logic [4:0]    idx, pr_idx;
  logic [31:0]   rd_data, pr_vec;

  assign idx     = addr[6:2];
  assign bus_go  = (bus_st == BUS_IDLE) && stb;
  assign wr      = bus_go && rw;
  assign ack     = (bus_st == BUS_ACK);
  assign int_req = (int_st == INT_REQ);
  assign take    = int_req && int_ack;
  assign elig    = pending & en & {NI{gen}};

`ifdef HS32_AICT_EDGE_EN
  logic [NI-1:0] irq_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) irq_q <= '0;
    else        irq_q <= irq;
  assign evt = irq & ~irq_q;
`else
  assign evt = irq;
`endif

  hs32_aict_prio #(.NI(NI)) u_prio (.req(elig), .vld(pr_vld), .idx(pr_idx));

  always_comb begin
    rd_data = '0;
    pr_vec  = '0;
    en      = '0;
    ack_clr = '0;
    for (int i = 0; i < NI; i++) begin
      en[i]      = tbl[i][0];
      ack_clr[i] = take && (int_line == 5'(i));
      if (idx == 5'(i))    rd_data = tbl[i];
      if (pr_idx == 5'(i)) pr_vec  = {tbl[i][31:2], 2'b00};
    end
    if (idx == IDX_PENDING) rd_data = 32'(pending);
    if (idx == IDX_CTRL)    rd_data = {31'b0, gen};
    bus_clr  = (wr && idx == IDX_PENDING) ? dtw[NI-1:0] : '0;
    // New events are OR'd in last so they win over any same-cycle clear.
    pend_nxt = (pending & ~(bus_clr | ack_clr)) | evt;
  end

  always_comb begin
    bus_nxt = bus_st;
    case (bus_st)
      BUS_IDLE: if (stb) bus_nxt = BUS_ACK;
      BUS_ACK:  bus_nxt = BUS_IDLE;
      default:  bus_nxt = BUS_IDLE;
    endcase
  end

  always_comb begin
    int_nxt = int_st;
    load    = 1'b0;
    case (int_st)
      INT_IDLE: if (pr_vld) begin
        int_nxt = INT_REQ;
        load    = 1'b1;
      end
      INT_REQ:  if (int_ack) int_nxt = INT_IDLE;
      default:  int_nxt = INT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus_st <= BUS_IDLE;
      int_st <= INT_IDLE;
    end else begin
      bus_st <= bus_nxt;
      int_st <= int_nxt;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dtr      <= '0;
      int_vec  <= '0;
      int_line <= '0;
      pending  <= '0;
      gen      <= 1'b0;
      tbl      <= '0;
    end else begin
      pending <= pend_nxt;
      if (load) begin
        int_line <= pr_idx;
        int_vec  <= pr_vec;
      end
      if (bus_go && !rw) dtr <= rd_data;
      if (wr) begin
        if (idx == IDX_CTRL) gen <= dtw[0];
        for (int i = 0; i < NI; i++)
          if (idx == 5'(i)) tbl[i] <= {dtw[31:2], 1'b0, dtw[0]};
      end
    end
endmodule

// File: tb/tb_hs32_aict.sv
// Directed self-checking bench for hs32_aict (level or edge build).
module tb_hs32_aict;
  localparam int NI = 24;

  logic          clk, reset, stb, ack, rw, int_req, int_ack;
  logic [31:0]   addr, dtw, dtr, int_vec, rd;
  logic [NI-1:0] irq;
  logic [4:0]    int_line;
  int total = 0;
  int bad   = 0;

  hs32_aict #(.NI(NI)) dut (
    .clk(clk), .reset(reset), .stb(stb), .ack(ack), .addr(addr), .dtw(dtw),
    .rw(rw), .dtr(dtr), .irq(irq), .int_req(int_req), .int_vec(int_vec),
    .int_line(int_line), .int_ack(int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after ack drops.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    stb = 1'b1; rw = w; addr = a; dtw = d;
    chk("ack_pre", 32'(ack), 32'd0);
    @(negedge clk);
    chk("ack_one", 32'(ack), 32'd1);
    stb = 1'b0;
    r = dtr;
    @(negedge clk);
    chk("ack_end", 32'(ack), 32'd0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stb = 1'b0; rw = 1'b0; addr = '0; dtw = '0; irq = '0; int_ack = 1'b0;
    cyc(2);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_dtr", dtr, 32'd0);
    chk("rst_int_vec", int_vec, 32'd0);
    chk("rst_int_line", 32'(int_line), 32'd0);
    reset = 1'b1;
    cyc(1);

    // table entry write/read
    bus(1, 32'h0000_0008, 32'h0000_1001, rd);
    bus(0, 32'h0000_0008, 32'h0, rd);
    chk("entry2_rd", rd, 32'h0000_1001);
    bus(1, 32'h0000_0008, 32'hFFFF_FFFF, rd);
    bus(0, 32'hFFFF_FF88, 32'h0, rd);
    chk("entry2_bit1_alias", rd, 32'hFFFF_FFFD);
    bus(1, 32'h0000_0008, 32'h0000_1001, rd);

    // single interrupt on line 2
    bus(1, 32'h0000_0064, 32'hFFFF_FFFF, rd);
    bus(0, 32'h0000_0064, 32'h0, rd);
    chk("ctrl_rd", rd, 32'h1);
    irq = 24'h4;
    cyc(1);
    irq = '0;
    cyc(1);
    chk("l2_int_req", 32'(int_req), 32'd1);
    chk("l2_int_line", 32'(int_line), 32'd2);
    chk("l2_int_vec", int_vec, 32'h0000_1000);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    chk("l2_req_drop", 32'(int_req), 32'd0);
    bus(0, 32'h0000_0060, 32'h0, rd);
    chk("l2_pending_clr", rd, 32'h0);

    // priority 3 over 7
    bus(1, 32'h0000_000C, 32'h0000_2001, rd);
    bus(1, 32'h0000_001C, 32'h0000_3001, rd);
    irq = 24'h88;
    cyc(1);
    irq = '0;
    cyc(1);
    chk("pri_line3", 32'(int_line), 32'd3);
    chk("pri_vec3", int_vec, 32'h0000_2000);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    chk("pri_idle_gap", 32'(int_req), 32'd0);
    cyc(1);
    chk("pri_req7", 32'(int_req), 32'd1);
    chk("pri_line7", 32'(int_line), 32'd7);
    chk("pri_vec7", int_vec, 32'h0000_3000);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;

    // global enable gating
    bus(1, 32'h0000_0064, 32'h0, rd);
    irq = 24'h4;
    cyc(1);
    irq = '0;
    cyc(3);
    chk("gen0_no_req", 32'(int_req), 32'd0);
    bus(0, 32'h0000_0060, 32'h0, rd);
    chk("gen0_pending", rd, 32'h4);
    bus(1, 32'h0000_0064, 32'h1, rd);
    chk("gen1_req", 32'(int_req), 32'd1);
    chk("gen1_line", 32'(int_line), 32'd2);
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;

    // unmapped index and W1C on PENDING
    bus(1, 32'h0000_007C, 32'hFFFF_FFFF, rd);
    bus(0, 32'h0000_007C, 32'h0, rd);
    chk("unmapped_rd", rd, 32'h0);
    bus(1, 32'h0000_0064, 32'h0, rd);
    irq = 24'hC;
    cyc(1);
    irq = '0;
    cyc(1);
    bus(0, 32'h0000_0060, 32'h0, rd);
    chk("w1c_before", rd, 32'hC);
    bus(1, 32'h0000_0060, 32'h4, rd);
    bus(0, 32'h0000_0060, 32'h0, rd);
    chk("w1c_after", rd, 32'h8);

    // reset mid-REQ while ack is high
    bus(1, 32'h0000_0064, 32'h1, rd);
    chk("pre_rst_req", 32'(int_req), 32'd1);
    chk("pre_rst_line", 32'(int_line), 32'd3);
    stb = 1'b1; rw = 1'b0; addr = 32'h0000_0060;
    @(posedge clk);
    #1;
    chk("pre_rst_ack", 32'(ack), 32'd1);
    stb = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_int_req", 32'(int_req), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_dtr", dtr, 32'd0);
    chk("arst_int_vec", int_vec, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    bus(0, 32'h0000_000C, 32'h0, rd);
    chk("arst_entry3", rd, 32'h0);
    bus(0, 32'h0000_0060, 32'h0, rd);
    chk("arst_pending", rd, 32'h0);
    bus(0, 32'h0000_0064, 32'h0, rd);
    chk("arst_ctrl", rd, 32'h0);

    // held irq across a bus clear
    bus(1, 32'h0000_0008, 32'h0000_1001, rd);
    irq = 24'h4;
    cyc(2);
    bus(0, 32'h0000_0060, 32'h0, rd);
    chk("held_pending", rd, 32'h4);
    bus(1, 32'h0000_0060, 32'h4, rd);
    bus(0, 32'h0000_0060, 32'h0, rd);
`ifdef HS32_AICT_EDGE_EN
    chk("held_after_clr", rd, 32'h0);
`else
    chk("held_after_clr", rd, 32'h4);
`endif
    irq = '0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
